// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ADD/SUB/XOR/SRA/OR/AND and an iterative shift-add MUL.
// Define ALU_FAST_MUL_EN to replace the iterative MUL with a single-cycle multiplier.
module alu_multicycle #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);
    localparam int N     = WIDTH / MUL_BITS;
    localparam int CNT_W = $clog2(N);
    localparam int SH_W  = $clog2(WIDTH);

    typedef enum logic {ST_IDLE, ST_MUL} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] op_result;
    logic [WIDTH-1:0] acc_next;

    function automatic logic [WIDTH-1:0] chunk_pp(input logic [WIDTH-1:0] mc,
                                                 input logic [MUL_BITS-1:0] bits);
        logic [WIDTH-1:0] pp;
        pp = '0;
        for (int unsigned i = 0; i < MUL_BITS; i++) begin
            if (bits[i]) pp = pp + (mc << i);
        end
        return pp;
    endfunction

    always_comb begin
        op_result = '0;
        case (ALUCtrl_i)
            3'b000: op_result = data1_i + data2_i;
            3'b001: op_result = data1_i - data2_i;
`ifdef ALU_FAST_MUL_EN
            3'b010: op_result = data1_i * data2_i;
`endif
            3'b100: op_result = data1_i ^ data2_i;
            3'b101: op_result = WIDTH'($signed(data1_i) >>> data2_i[SH_W-1:0]);
            3'b110: op_result = data1_i | data2_i;
            3'b111: op_result = data1_i & data2_i;
            default: op_result = '0;
        endcase
    end

    // The first multiplier chunk is retired at the accept edge, so the last of the
    // N steps lands on the edge that makes done_o visible N cycles after acceptance.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        done_d   = 1'b0;
        acc_next = acc_q + chunk_pp(mcand_q, mplier_q[MUL_BITS-1:0]);
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
`ifdef ALU_FAST_MUL_EN
                    data_d = op_result;
                    done_d = 1'b1;
`else
                    if (ALUCtrl_i == 3'b010) begin
                        state_d  = ST_MUL;
                        acc_d    = chunk_pp(data1_i, data2_i[MUL_BITS-1:0]);
                        mcand_d  = data1_i << MUL_BITS;
                        mplier_d = data2_i >> MUL_BITS;
                        cnt_d    = CNT_W'(1);
                    end else begin
                        data_d = op_result;
                        done_d = 1'b1;
                    end
`endif
                end
            end
            ST_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    data_d  = acc_next;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign done_o  = done_q;
    assign data_o  = data_q;
    assign Zero_o  = (data_q == '0);
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with a scoreboard of expected results and done cycles.
module tb_alu_multicycle;
    localparam int WIDTH = 32;
`ifdef ALU_FAST_MUL_EN
    localparam int unsigned MUL_LAT = 1;
`else
    localparam int unsigned MUL_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  ctrl = '0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        ready_o, done_o, Zero_o;
    logic [31:0] data_o;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    string       tags[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    alu_multicycle #(.WIDTH(WIDTH), .MUL_BITS(1)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .ALUCtrl_i(ctrl),
        .data1_i  (d1),
        .data2_i  (d2),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .data_o   (data_o),
        .Zero_o   (Zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done_o must match the oldest expectation in value and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $error("FAIL %s_done_missing observed_cycle=%0d expected_cycle=%0d",
                       tags[0], cyc, sb[0].cyc);
                void'(sb.pop_front());
                void'(tags.pop_front());
            end
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {31'b0, done_o}, 32'd0);
                end else begin
                    exp_t  e;
                    string t;
                    e = sb.pop_front();
                    t = tags.pop_front();
                    check({t, "_data"}, data_o, e.data);
                    check({t, "_cycle"}, cyc, e.cyc);
                    check({t, "_zero"}, {31'b0, Zero_o}, {31'b0, e.data == 32'd0});
                end
            end
`ifdef ALU_FAST_MUL_EN
            check("fast_ready", {31'b0, ready_o}, 32'd1);
`endif
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int unsigned lat, input string tag,
                         input bit push);
        ctrl  = op;
        d1    = a;
        d2    = b;
        valid = 1'b1;
        if (push) begin
            sb.push_back('{data: exp, cyc: cyc + lat});
            tags.push_back(tag);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [31:0] a, b;
        int unsigned e_cyc;

        #2;
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_zero", {31'b0, Zero_o}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(3'b000, 32'd7, 32'd5, 32'd12, 1, "add_7_5", 1);
        issue(3'b001, 32'd5, 32'd5, 32'd0, 1, "sub_5_5", 1);
        issue(3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, "sub_0_1", 1);
        issue(3'b101, 32'h8000_0000, 32'h23, 32'hF000_0000, 1, "sra", 1);
        issue(3'b100, 32'hA5, 32'hFF, 32'h5A, 1, "xor", 1);
        issue(3'b110, 32'h1200_0034, 32'h0056_0000, 32'h1256_0034, 1, "or", 1);
        issue(3'b011, 32'd5, 32'd6, 32'd0, 1, "reserved", 1);
        issue(3'b000, 32'hFFFF_FFFF, 32'd2, 32'd1, 1, "add_wrap", 1);
        drain();

        e_cyc = cyc + MUL_LAT;
        issue(3'b010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, MUL_LAT, "mul_max", 1);
        while (cyc < e_cyc) begin
            ctrl  = 3'($urandom);
            d1    = $urandom;
            d2    = $urandom;
            valid = 1'b1;
            @(negedge clk);
            check("busy_ready", {31'b0, ready_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        issue(3'b111, 32'hF0F0, 32'h0FF0, 32'h00F0, 1, "and_b2b", 1);
        drain();

        issue(3'b010, 32'd1234, 32'd5678, 32'd7006652, MUL_LAT, "mul_1234_5678", 1);
        drain();
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            issue(3'b010, a, b, a * b, MUL_LAT, "mul_rand", 1);
            drain();
        end
        issue(3'b000, 32'd40, 32'd2, 32'd42, 1, "add_pre_abort", 1);
        drain();

`ifndef ALU_FAST_MUL_EN
        issue(3'b010, 32'd1234, 32'd5678, 32'd0, 0, "abort", 0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy", {31'b0, ready_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready", {31'b0, ready_o}, 32'd1);
        check("abort_done", {31'b0, done_o}, 32'd0);
        check("abort_data", data_o, 32'd0);
        check("abort_zero", {31'b0, Zero_o}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        issue(3'b000, 32'd7, 32'd5, 32'd12, 1, "add_post_abort", 1);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
